// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Optional ARB_ROUND_ROBIN_EN: ties in IDLE alternate instead of favouring data.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  dm_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // state   | meaning
  // IDLE    | no access in flight, arbitrate eligible requests
  // BUSY_IF | fetch read in flight, counting latency
  // BUSY_DM | data read/write in flight, counting latency
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  if_ack_d, dm_ack_d;
  logic                  mem_en_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_d, dm_rdata_d;
  logic                  if_elig, dm_elig;
  logic                  grant_if, grant_dm;

  // A request seen during its own ack cycle has already been served.
  assign if_elig = if_req & ~if_ack;
  assign dm_elig = dm_req & ~dm_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm_q, last_dm_d;

  assign grant_dm = dm_elig & (~if_elig | ~last_dm_q);

  always_comb begin
    last_dm_d = last_dm_q;
    if (state_q == IDLE && (if_elig || dm_elig)) begin
      last_dm_d = grant_dm;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_dm_q <= 1'b0;
    end else begin
      last_dm_q <= last_dm_d;
    end
  end
`else
  assign grant_dm = dm_elig;
`endif

  assign grant_if = if_elig & ~grant_dm;

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;

    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = BUSY_DM;
          cnt_d       = LAT;
          wr_d        = dm_we;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (grant_if) begin
          state_d    = BUSY_IF;
          cnt_d      = LAT;
          wr_d       = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
        end
      end

      BUSY_IF: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          if_rdata_d = mem_rdata;
          if_ack_d   = 1'b1;
          state_d    = IDLE;
        end
      end

      BUSY_DM: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          dm_ack_d = 1'b1;
          state_d  = IDLE;
          if (!wr_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      if_ack    <= if_ack_d;
      dm_ack    <= dm_ack_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against an edge-numbered transaction model.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack, if_stall;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack, dm_stall;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Transaction model: an access granted at edge g completes at edge g+LAT.
  int            cyc;
  bit            m_busy, m_own_dm, m_wr, m_last_dm;
  int            m_grant_cyc;
  bit            m_if_ack, m_dm_ack, m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;
  bit            rand_mem;
  int            obs_cyc[$];
  logic [AW-1:0] obs_addr[$];

  function automatic void model_reset();
    m_busy = 0; m_own_dm = 0; m_wr = 0; m_last_dm = 0; m_grant_cyc = 0;
    m_if_ack = 0; m_dm_ack = 0; m_en = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
  endfunction

  function automatic void model_step();
    bit eif, edm, gdm;
    eif = if_req && !m_if_ack;
    edm = dm_req && !m_dm_ack;
    m_if_ack = 0; m_dm_ack = 0; m_en = 0; m_we = 0;
    if (m_busy) begin
      if (cyc == m_grant_cyc + LAT) begin
        m_busy = 0;
        if (m_own_dm) begin
          m_dm_ack = 1;
          if (!m_wr) m_dm_rdata = mem_rdata;
        end else begin
          m_if_ack   = 1;
          m_if_rdata = mem_rdata;
        end
      end
    end else if (eif || edm) begin
`ifdef ARB_ROUND_ROBIN_EN
      gdm = edm && (!eif || !m_last_dm);
`else
      gdm = edm;
`endif
      m_busy = 1; m_grant_cyc = cyc; m_own_dm = gdm; m_en = 1; m_last_dm = gdm;
      if (gdm) begin
        m_wr = dm_we; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
      end else begin
        m_wr = 0; m_addr = if_addr;
      end
    end
  endfunction

  task automatic compare_all();
    check("if_ack",    if_ack,    m_if_ack);
    check("dm_ack",    dm_ack,    m_dm_ack);
    check("mem_en",    mem_en,    m_en);
    check("mem_we",    mem_we,    m_we);
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("if_rdata",  if_rdata,  m_if_rdata);
    check("dm_rdata",  dm_rdata,  m_dm_rdata);
    check("if_stall",  if_stall,  if_req & ~m_if_ack);
    check("dm_stall",  dm_stall,  dm_req & ~m_dm_ack);
  endtask

  task automatic cycle();
    @(posedge clock);
    cyc++;
    model_step();
    #1;
    compare_all();
    if (mem_en) begin
      obs_cyc.push_back(cyc);
      obs_addr.push_back(mem_addr);
    end
    if (rand_mem) mem_rdata = $urandom;
  endtask

  task automatic wait_ack(input bit dm, input int budget, output int at);
    int n = 0;
    at = -1;
    do begin
      cycle();
      n++;
    end while (!(dm ? dm_ack : if_ack) && n < budget);
    if (dm ? dm_ack : if_ack) at = cyc;
    else check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int at, g, dm_seen, acks;
    cyc = 0;
    rand_mem = 0;
    model_reset();
    #1;
    compare_all();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    // Single fetch with a fixed memory word
    mem_rdata = 32'h2001_0005;
    obs_cyc.delete(); obs_addr.delete();
    if_req = 1; if_addr = 32'h40;
    wait_ack(0, 10, at);
    if_req = 0;
    check("t1_rdata", if_rdata, 32'h2001_0005);
    check("t1_npulse", obs_cyc.size(), 1);
    if (obs_cyc.size() > 0) check("t1_latency", at - obs_cyc[0], LAT);
    idle(2);

    // Simultaneous requests: data first, fetch right after the data ack
    mem_rdata = 32'h1122_3344;
    obs_cyc.delete(); obs_addr.delete();
    dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    if_req = 1; if_addr = 32'h44;
    wait_ack(1, 10, at);
    dm_req = 0;
    check("t2_dm_rdata", dm_rdata, 32'h1122_3344);
    wait_ack(0, 10, at);
    if_req = 0;
    check("t2_npulse", obs_cyc.size(), 2);
    if (obs_cyc.size() == 2) begin
      check("t2_first",  obs_addr[0], 32'h80);
      check("t2_second", obs_addr[1], 32'h44);
      check("t2_gap",    obs_cyc[1] - obs_cyc[0], LAT + 1);
    end
    idle(2);

    // Write keeps the previous read data
    mem_rdata = 32'h5555_AAAA;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    cycle();
    dm_req = 1;
    check("t3_en", mem_en, 1);
    check("t3_we", mem_we, 1);
    check("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_ack(1, 10, at);
    dm_req = 0; dm_we = 0;
    check("t3_dm_rdata_kept", dm_rdata, 32'h1122_3344);
    idle(2);

    // Held fetch request: four accesses, one idle ack cycle between each
    obs_cyc.delete(); obs_addr.delete();
    if_req = 1; if_addr = 32'h0;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      cycle();
      if (if_ack) begin
        acks++;
        if_addr = if_addr + 32'h4;
        if (acks == 4) if_req = 0;
      end
    end
    if_req = 0;
    check("t4_acks", acks, 4);
    check("t4_npulse", obs_cyc.size(), 4);
    for (int i = 0; i < obs_cyc.size() && i < 4; i++) begin
      check("t4_addr", obs_addr[i], 32'(i * 4));
      if (i > 0) check("t4_gap", obs_cyc[i] - obs_cyc[i-1], LAT + 2);
    end
    idle(2);

    // Reset one cycle after a data grant discards the access
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    g = 0;
    for (int i = 0; i < 10 && !mem_en; i++) cycle();
    check("t5_grant", mem_en, 1);
    cycle();
    reset = 1'b0;
    dm_req = 0;
    #1;
    model_reset();
    compare_all();
    @(posedge clock);
    #1;
    compare_all();
    @(negedge clock);
    reset = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    obs_cyc.delete(); obs_addr.delete();
    if_req = 1; if_addr = 32'h300;
    dm_seen = 0;
    for (int i = 0; i < 10 && !if_ack; i++) begin
      cycle();
      if (dm_ack) dm_seen++;
    end
    if_req = 0;
    check("t5_no_dm_ack", dm_seen, 0);
    check("t5_if_ack", if_ack, 1);
    check("t5_if_rdata", if_rdata, 32'h0BAD_F00D);
    if (obs_cyc.size() > 0) check("t5_latency", cyc - obs_cyc[0], LAT);
    idle(2);

    // Both held: grants alternate DM, IF, DM, IF
    obs_cyc.delete(); obs_addr.delete();
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    if_req = 1; if_addr = 32'h1000;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      cycle();
      if (if_ack || dm_ack) acks++;
      if (acks == 4) begin
        if_req = 0; dm_req = 0;
      end
    end
    if_req = 0; dm_req = 0;
    check("t6_npulse", obs_addr.size(), 4);
    for (int i = 0; i < obs_addr.size() && i < 4; i++)
      check("t6_order", obs_addr[i], (i % 2 == 0) ? 32'h2000 : 32'h1000);
    idle(2);

    // Random traffic against the model
    rand_mem = 1;
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (if_req) begin
        if (if_ack) begin
          if ($urandom_range(1) == 0) if_req = 0;
          else if_addr = $urandom;
        end else if ($urandom_range(15) == 0) begin
          if_req = 0;
        end else if ($urandom_range(7) == 0) begin
          if_addr = $urandom;
        end
      end else if ($urandom_range(2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_req) begin
        if (dm_ack) begin
          if ($urandom_range(1) == 0) dm_req = 0;
          else begin
            dm_addr = $urandom; dm_we = 1'($urandom_range(1)); dm_wdata = $urandom;
          end
        end else if ($urandom_range(15) == 0) begin
          dm_req = 0;
        end else if ($urandom_range(7) == 0) begin
          dm_addr = $urandom; dm_we = 1'($urandom_range(1)); dm_wdata = $urandom;
        end
      end else if ($urandom_range(2) == 0) begin
        dm_req = 1; dm_addr = $urandom; dm_we = 1'($urandom_range(1)); dm_wdata = $urandom;
      end
    end
    if_req = 0; dm_req = 0;
    idle(LAT + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
